// File: rtl/clock_route_sequencer.sv
// Sequences enable/disable of gated clock routes one at a time, waits for each gate's
// acknowledge, then enforces a settle gap. Optional ack timeout: CLOCK_ROUTE_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transition in flight; picks next pending route (round-robin)
// WAIT_ACK | route_enable[cur] driven to target, waiting for route_ack[cur]
// SETTLE   | quiet gap of SETTLE_CYCLES after any route transition
module clock_route_sequencer #(
   parameter int NUM_ROUTE      = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [NUM_ROUTE-1:0] route_req,
   output logic [NUM_ROUTE-1:0] route_enable,
   input  logic [NUM_ROUTE-1:0] route_ack,
   output logic [NUM_ROUTE-1:0] route_status,
   output logic                 busy,
   output logic [NUM_ROUTE-1:0] timeout_err,
   input  logic                 err_clear
);

   localparam int PW = (NUM_ROUTE > 1) ? $clog2(NUM_ROUTE) : 1;
   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_SETTLE   = 2'd2
   } state_t;

   // After a transition, a zero-length settle goes straight back to IDLE.
   localparam state_t ST_AFTER = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;

   state_t               r_state, w_nxt_state;
   logic [NUM_ROUTE-1:0] r_enable, w_nxt_enable;
   logic [NUM_ROUTE-1:0] r_status, w_nxt_status;
   logic [PW-1:0]        r_ptr, w_nxt_ptr;
   logic [PW-1:0]        r_cur, w_nxt_cur;
   logic                 r_target, w_nxt_target;
   logic [SW-1:0]        r_scnt, w_nxt_scnt;
   logic                 r_busy;

   logic [NUM_ROUTE-1:0] w_err_mask;
   logic [NUM_ROUTE-1:0] w_pending;
   logic [PW-1:0]        w_sel;
   logic [PW-1:0]        w_idx;
   logic                 w_any;
   logic [PW-1:0]        w_ptr_adv;

`ifdef CLOCK_ROUTE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]        r_tcnt, w_nxt_tcnt;
   logic [NUM_ROUTE-1:0] r_err, w_nxt_err;
   assign w_err_mask = r_err;
`else
   wire w_unused_cfg = err_clear & (TIMEOUT_CYCLES != 0);
   assign w_err_mask = '0;
`endif

   assign w_pending = (route_req ^ r_status) & ~w_err_mask;
   assign w_ptr_adv = (r_cur == PW'(NUM_ROUTE - 1)) ? '0 : r_cur + PW'(1);

   // Walk from the highest offset down so the lowest offset from r_ptr wins.
   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      w_idx = '0;
      for (int i = NUM_ROUTE - 1; i >= 0; i--) begin
         w_idx = PW'((int'(r_ptr) + i) % NUM_ROUTE);
         if (w_pending[w_idx]) begin
            w_sel = w_idx;
            w_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_enable = r_enable;
      w_nxt_status = r_status;
      w_nxt_ptr    = r_ptr;
      w_nxt_cur    = r_cur;
      w_nxt_target = r_target;
      w_nxt_scnt   = r_scnt;
`ifdef CLOCK_ROUTE_TIMEOUT_EN
      w_nxt_tcnt   = r_tcnt;
      w_nxt_err    = err_clear ? '0 : r_err;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_nxt_cur             = w_sel;
               w_nxt_target          = route_req[w_sel];
               w_nxt_enable[w_sel]   = route_req[w_sel];
               w_nxt_state           = ST_WAIT_ACK;
`ifdef CLOCK_ROUTE_TIMEOUT_EN
               w_nxt_tcnt            = TW'(TIMEOUT_CYCLES);
`endif
            end
         end
         ST_WAIT_ACK: begin
            if (route_ack[r_cur] == r_target) begin
               w_nxt_status[r_cur] = r_target;
               w_nxt_ptr           = w_ptr_adv;
               w_nxt_scnt          = SW'(SETTLE_CYCLES);
               w_nxt_state         = ST_AFTER;
            end
`ifdef CLOCK_ROUTE_TIMEOUT_EN
            else if (r_tcnt <= TW'(1)) begin
               w_nxt_err[r_cur]    = 1'b1;
               w_nxt_enable[r_cur] = r_status[r_cur];
               w_nxt_ptr           = w_ptr_adv;
               w_nxt_scnt          = SW'(SETTLE_CYCLES);
               w_nxt_state         = ST_AFTER;
            end else begin
               w_nxt_tcnt = r_tcnt - TW'(1);
            end
`endif
         end
         ST_SETTLE: begin
            if (r_scnt <= SW'(1)) begin
               w_nxt_scnt  = '0;
               w_nxt_state = ST_IDLE;
            end else begin
               w_nxt_scnt = r_scnt - SW'(1);
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_enable <= '0;
         r_status <= '0;
         r_ptr    <= '0;
         r_cur    <= '0;
         r_target <= 1'b0;
         r_scnt   <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_enable <= w_nxt_enable;
         r_status <= w_nxt_status;
         r_ptr    <= w_nxt_ptr;
         r_cur    <= w_nxt_cur;
         r_target <= w_nxt_target;
         r_scnt   <= w_nxt_scnt;
         r_busy   <= (w_nxt_state != ST_IDLE);
      end
   end

`ifdef CLOCK_ROUTE_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_tcnt <= '0;
         r_err  <= '0;
      end else begin
         r_tcnt <= w_nxt_tcnt;
         r_err  <= w_nxt_err;
      end
   end
   assign timeout_err = r_err;
`else
   assign timeout_err = '0;
`endif

   assign route_enable = r_enable;
   assign route_status = r_status;
   assign busy         = r_busy;

endmodule
